// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the lifo_stack block.
// Operation-decode encoding and pointer-width helper.
package lifo_stack_pkg;

    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_TOS     = 3'd4
    } op_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Storage array for lifo_stack: synchronous write, asynchronous read, no reset.
module lifo_stack_mem #(
    parameter int WORD  = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic            clk,
    input  logic            w_we,
    input  logic [AW-1:0]   w_waddr,
    input  logic [WORD-1:0] w_wdata,
    input  logic [AW-1:0]   w_raddr,
    output logic [WORD-1:0] w_rdata
);

    logic [WORD-1:0] r_mem [DEPTH];

    // Single write port, one entry per cycle.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_rdata = r_mem[w_raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with replace-top, status and sticky error flags.
// Optional high-water tracking is enabled by defining LIFO_STACK_WATERMARK_EN.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter  int WORD  = 8,
    parameter  int DEPTH = 64,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WORD-1:0]  d_in,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             err_clr,
    output logic [WORD-1:0]  d_out,
    output logic             d_valid,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             overflow,
`ifdef LIFO_STACK_WATERMARK_EN
    output logic [PTR_W:0]   high_water,
`endif
    output logic             underflow
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]   r_count;
    logic [WORD-1:0]  r_d_out;
    logic             r_d_valid;
    logic             r_overflow;
    logic             r_underflow;

    op_e              w_op;
    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic             w_rd;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic [PTR_W-1:0] w_top;
    logic [PTR_W-1:0] w_waddr;
    logic [PTR_W:0]   w_count_nxt;
    logic [WORD-1:0]  w_rdata;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == {(PTR_W+1){1'b0}});
    // Truncated subtraction still yields DEPTH-1 when full, since the top index fits PTR_W bits.
    assign w_top   = r_count[PTR_W-1:0] - PTR_W'(1);

    // Decode the request into a single operation plus error conditions.
    always_comb begin
        w_op      = OP_IDLE;
        w_udf_set = 1'b0;
        case ({push, pop})
            2'b11: begin
                if (w_empty) begin
                    w_op = OP_PUSH;
                end else begin
                    w_op = OP_REPLACE;
                end
            end
            2'b10: w_op = OP_PUSH;
            2'b01: begin
                if (w_empty) begin
                    w_udf_set = 1'b1;
                end else begin
                    w_op = OP_POP;
                end
            end
            2'b00: begin
                if (tos && w_empty) begin
                    w_udf_set = 1'b1;
                end else if (tos) begin
                    w_op = OP_TOS;
                end else begin
                    w_op = OP_IDLE;
                end
            end
            default: w_op = OP_IDLE;
        endcase
    end

    // Translate the decoded operation into memory and counter actions.
    always_comb begin
        w_we        = 1'b0;
        w_rd        = 1'b0;
        w_ovf_set   = 1'b0;
        w_waddr     = r_count[PTR_W-1:0];
        w_count_nxt = r_count;
        case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + (PTR_W+1)'(1);
                end
            end
            OP_REPLACE: begin
                w_we    = 1'b1;
                w_rd    = 1'b1;
                w_waddr = w_top;
            end
            OP_POP: begin
                w_rd        = 1'b1;
                w_count_nxt = r_count - (PTR_W+1)'(1);
            end
            OP_TOS:  w_rd = 1'b1;
            OP_IDLE: w_rd = 1'b0;
            default: w_rd = 1'b0;
        endcase
    end

    lifo_stack_mem #(
        .WORD  (WORD),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .w_we    (w_we),
        .w_waddr (w_waddr),
        .w_wdata (d_in),
        .w_raddr (w_top),
        .w_rdata (w_rdata)
    );

    // Occupancy, read register, strobe and sticky flags (set beats clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= {(PTR_W+1){1'b0}};
            r_d_out     <= {WORD{1'b0}};
            r_d_valid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_d_valid   <= w_rd;
            r_overflow  <= (r_overflow  & ~err_clr) | w_ovf_set;
            r_underflow <= (r_underflow & ~err_clr) | w_udf_set;
            if (w_rd) begin
                r_d_out <= w_rdata;
            end
        end
    end

`ifdef LIFO_STACK_WATERMARK_EN
    logic [PTR_W:0] r_high_water;

    // Peak occupancy tracked against the post-update count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_high_water <= {(PTR_W+1){1'b0}};
        end else if (err_clr) begin
            r_high_water <= w_count_nxt;
        end else if (w_count_nxt > r_high_water) begin
            r_high_water <= w_count_nxt;
        end
    end

    assign high_water = r_high_water;
`endif

    assign d_out     = r_d_out;
    assign d_valid   = r_d_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed, scoreboard-checked bench for lifo_stack (DEPTH=4, WORD=8).
module tb_lifo_stack;

    localparam int WORD  = 8;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WORD-1:0]  d_in = 8'h00;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             tos = 1'b0;
    logic             err_clr = 1'b0;
    logic [WORD-1:0]  d_out;
    logic             d_valid;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             underflow;
`ifdef LIFO_STACK_WATERMARK_EN
    logic [PTR_W:0]   high_water;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [WORD-1:0] exp_q[$];

    lifo_stack #(.WORD(WORD), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .push       (push),
        .pop        (pop),
        .tos        (tos),
        .err_clr    (err_clr),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
`ifdef LIFO_STACK_WATERMARK_EN
        .high_water (high_water),
`endif
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [WORD-1:0] e;
        if (rst && d_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: d_valid=%b d_out=0x%0h with no read outstanding", d_valid, d_out);
            end else begin
                e = exp_q.pop_front();
                chk("d_out", {24'h0, d_out}, {24'h0, e});
            end
        end
    end

    task automatic cyc(input logic pu, input logic po, input logic t, input logic ec, input logic [WORD-1:0] d);
        push = pu; pop = po; tos = t; err_clr = ec; d_in = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_push(input logic [WORD-1:0] d);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic do_pop(input logic [WORD-1:0] e);
        exp_q.push_back(e);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_tos(input logic [WORD-1:0] e);
        exp_q.push_back(e);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_flags", {overflow, underflow, d_valid}, 0);
        rst = 1'b1;

        // Reset in the middle of activity.
        do_push(8'h11);
        do_push(8'h22);
        do_tos(8'h22);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_d_out", d_out, 0);
        chk("midrst_valid", d_valid, 0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("empty_pop_udf", underflow, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_udf", underflow, 0);

        // LIFO ordering.
        do_push(8'hA1);
        do_push(8'hB2);
        do_push(8'hC3);
        chk("lifo_count3", count, 3);
        do_pop(8'hC3);
        do_pop(8'hB2);
        do_pop(8'hA1);
        chk("lifo_count0", count, 0);
        chk("lifo_empty", empty, 1);

        // Full boundary and overflow.
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        do_push(8'h04);
        chk("full_flag", full, 1);
        chk("full_count", count, 4);
        do_push(8'hEE);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 4);
        do_pop(8'h04);
        chk("ovf_pop_count", count, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_ovf", overflow, 0);
        do_pop(8'h03);
        do_pop(8'h02);
        do_pop(8'h01);

        // Replace-top, and push+pop on an empty stack.
        do_push(8'h05);
        do_push(8'h06);
        exp_q.push_back(8'h06);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
        chk("repl_count", count, 2);
        do_tos(8'h07);
        do_pop(8'h07);
        do_pop(8'h05);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h09);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_udf", underflow, 0);
        do_tos(8'h09);
        do_pop(8'h09);

        // tos on empty and err_clr priority.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("tos_empty_udf", underflow, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_alone", underflow, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("clr_vs_set", underflow, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        do_push(8'h3C);
        do_tos(8'h3C);
        chk("tos_count", count, 1);

`ifdef LIFO_STACK_WATERMARK_EN
        do_pop(8'h3C);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("hw_clr0", high_water, 0);
        do_push(8'h41);
        do_push(8'h42);
        do_push(8'h43);
        do_pop(8'h43);
        do_pop(8'h42);
        do_push(8'h44);
        chk("hw_peak", high_water, 3);
        chk("hw_count", count, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("hw_clr", high_water, 2);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
Parametrised LIFO stack for multicycle-datapath operand/return storage. It generalises the single-mode push/pop stack with:
- configurable width and depth
- full/empty/count status
- simultaneous push+pop (replace-top)
- sticky overflow/underflow error flags
- a registered output-valid strobe
Sits beside the register file and is driven by the control-unit FSM.

Parameters:
WORD, 8, data width in bits
DEPTH, 64, number of entries (≥2, power of two not required)
PTR_W, $clog2(DEPTH), pointer width (derived localparam; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
d_in  input  WORD  data to push
push  input  1  push request
pop  input  1  pop request
tos  input  1  read top-of-stack without removing it
err_clr  input  1  clear sticky error flags
d_out  output  WORD  registered read data
d_valid  output  1  one-cycle strobe: d_out updated this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  PTR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push attempted while full (not replace)
underflow  output  1  sticky: pop/tos attempted while empty

Behaviour:
- Reset (rst low, asynchronous): count=0, d_out=0, d_valid=0, overflow=0, underflow=0. Storage array is not reset. Release is synchronous to next clk edge.
- All state updates on posedge clk. full/empty are combinational from the count register.
- Top entry index = count-1. Storage is written at index count on push.
- Operation decode, evaluated each cycle in priority order:
  1. push&pop, count>0 (REPLACE): d_out<=mem[count-1]; mem[count-1]<=d_in; count unchanged; d_valid=1. Permitted when full.
  2. push&pop, count==0: treated as plain push; d_out holds; d_valid=0; no underflow.
  3. pop only, count>0: d_out<=mem[count-1]; count<=count-1; d_valid=1.
  4. pop only, count==0: no change to count/d_out; underflow<=1; d_valid=0.
  5. push only, count<DEPTH: mem[count]<=d_in; count<=count+1; d_valid=0.
  6. push only, count==DEPTH: write dropped; count holds; overflow<=1.
  7. tos only (no push/pop), count>0: d_out<=mem[count-1]; d_valid=1.
  8. tos only, count==0: underflow<=1; d_out holds; d_valid=0.
  9. Idle: d_out holds; d_valid=0.
- tos is ignored whenever push or pop is asserted.
- Latency: read data is valid on the edge after the request (1 cycle). Push data is readable by pop/tos in the very next cycle.
- err_clr clears both sticky flags. If a new error occurs in the same cycle, set wins.
- Count never wraps. Pointer arithmetic is done at PTR_W+1 bits.

Optional Feature:
LIFO_STACK_WATERMARK_EN
- Defined: adds output high_water [PTR_W:0], the maximum count reached since reset. Reset value 0. Updated on the same edge as count, using the new count value. Cleared by err_clr to the current count.
- Undefined: port and logic are absent; nothing else changes.

Decomposition:
- Package lifo_stack_pkg holds:
  - op-decode enum {OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE, OP_TOS}
  - function ptr_w(depth) returning $clog2
- One sub-module, lifo_stack_mem: synchronous-write, asynchronous-read WORD×DEPTH array with write enable and address. It has no reset.
- Control (count, flags, d_out register) lives in lifo_stack.

Test Plan:
- Reset mid-operation: push 0x11,0x22, assert rst low between edges → count=0, empty=1, d_out=0 immediately; pop next → underflow=1, d_valid=0.
- LIFO order: push 0xA1,0xB2,0xC3 then pop×3 → d_out 0xC3,0xB2,0xA1 on successive cycles with d_valid=1 each; count 3→0, empty=1.
- Full boundary (DEPTH=4): push 4 values → full=1, count=4; 5th push 0xEE → overflow=1, count=4; pop → returns 4th value, not 0xEE.
- Replace: stack [0x05,0x06], push&pop with d_in=0x07 → d_out=0x06, count=2; tos → d_out=0x07. On an empty stack, push&pop 0x09 → count=1, d_valid=0, no underflow.
- tos/err_clr: empty tos → underflow=1; err_clr alone → 0; err_clr with a concurrent empty pop → stays 1. tos on [0x3C] → d_out=0x3C, count=1.
- Watermark (macro on): push 3, pop 2, push 1 → high_water=3, count=2; err_clr → high_water=2.
